// File: rtl/sap1_ctrl_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, T-state
// encodings, control-word field positions and the fixed control words.
package sap1_ctrl_pkg;

    // Opcodes (upper nibble of the instruction register)
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot T-states of the ring counter; bit0 = T1 ... bit5 = T6
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    // Bit positions inside the 12-bit control word
    // {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}; n* strobes are active-low
    localparam int CB_CP  = 11;
    localparam int CB_EP  = 10;
    localparam int CB_NLM = 9;
    localparam int CB_NCE = 8;
    localparam int CB_NLI = 7;
    localparam int CB_NEI = 6;
    localparam int CB_NLA = 5;
    localparam int CB_EA  = 4;
    localparam int CB_SU  = 3;
    localparam int CB_EU  = 2;
    localparam int CB_NLB = 1;
    localparam int CB_NLO = 0;

    // Control words
    localparam logic [11:0] CW_FETCH_ADDR  = 12'h5E3; // Ep, nLm
    localparam logic [11:0] CW_INC_PC      = 12'hBE3; // Cp
    localparam logic [11:0] CW_LOAD_IR     = 12'h263; // nCE, nLi
    localparam logic [11:0] CW_MAR_FROM_IR = 12'h1A3; // nLm, nEi
    localparam logic [11:0] CW_A_FROM_RAM  = 12'h2C3; // nCE, nLa
    localparam logic [11:0] CW_B_FROM_RAM  = 12'h2E1; // nCE, nLb
    localparam logic [11:0] CW_A_FROM_SUM  = 12'h3C7; // Eu, nLa
    localparam logic [11:0] CW_A_FROM_DIFF = 12'h3CF; // Su, Eu, nLa
    localparam logic [11:0] CW_OUT_FROM_A  = 12'h3F2; // Ea, nLo
    localparam logic [11:0] CW_IDLE        = 12'h3E3; // nothing active

    // True for the five opcodes the SAP-1 implements
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap1_ctrl_ring_counter.sv
// One-hot T1..T6 ring counter. Freezes while hold_i is high, jumps back to
// T1 on early_clear_i, and recovers from any non-one-hot value to T1.
module sap1_ring_counter
    import sap1_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       early_clear_i,
    output logic [5:0] tstate_o
);

    logic [5:0] state_q;
    logic [5:0] state_d;
    logic       legal;

    // Exactly one bit set: nonzero and no second bit left after clearing the lowest
    assign legal = (state_q != 6'd0) && ((state_q & (state_q - 6'd1)) == 6'd0);

    // Next-state selection: illegal recovery, hold, early return, then rotate
    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = T1;
        end else if (hold_i) begin
            state_d = state_q;
        end else if (early_clear_i) begin
            state_d = T1;
        end else begin
            state_d = {state_q[4:0], state_q[5]};
        end
    end

    // State register; reset wins over everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign tstate_o = state_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: ring counter plus opcode/T-state decode into the
// 12-bit control word, and the halt flag.
// Optional macro SAP1_EARLY_RETURN_EN: variable-length machine cycle
// (OUT/NOP return to T1 after T4, LDA after T5).
module sap1_controller_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter logic HALT_ON_UNDEF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    output logic [11:0] controlbus,
    output logic [5:0]  tstate,
    output logic        hlt
);

    logic        hlt_q;
    logic        hlt_d;
    logic        halt_op;
    logic        nop_op;
    logic        early_clear;
    logic [5:0]  tstate_w;
    logic [11:0] cw;

    // HLT, plus undefined opcodes when they are configured to halt
    assign halt_op = (opcode == OP_HLT) || (HALT_ON_UNDEF && !op_is_defined(opcode));
    assign nop_op  = !HALT_ON_UNDEF && !op_is_defined(opcode);

`ifdef SAP1_EARLY_RETURN_EN
    // Skip the idle tail of short instructions
    assign early_clear = ((tstate_w == T4) && ((opcode == OP_OUT) || nop_op)) ||
                         ((tstate_w == T5) && (opcode == OP_LDA));
`else
    assign early_clear = 1'b0;
`endif

    sap1_ring_counter u_ring (
        .clk_i         (clk),
        .rst_i         (rst),
        .hold_i        (hlt_q),
        .early_clear_i (early_clear),
        .tstate_o      (tstate_w)
    );

    // Halt is sticky: set on leaving T4 of a halting opcode, cleared only by reset
    assign hlt_d = hlt_q || ((tstate_w == T4) && halt_op);

    // Halt flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            hlt_q <= 1'b0;
        end else begin
            hlt_q <= hlt_d;
        end
    end

    // Control-word decode; fetch states ignore the opcode entirely
    always_comb begin
        cw = CW_IDLE;
        if (!hlt_q) begin
            case (tstate_w)
                T1: cw = CW_FETCH_ADDR;
                T2: cw = CW_INC_PC;
                T3: cw = CW_LOAD_IR;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: cw = CW_MAR_FROM_IR;
                        OP_OUT:                 cw = CW_OUT_FROM_A;
                        default:                cw = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         cw = CW_A_FROM_RAM;
                        OP_ADD, OP_SUB: cw = CW_B_FROM_RAM;
                        default:        cw = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  cw = CW_A_FROM_SUM;
                        OP_SUB:  cw = CW_A_FROM_DIFF;
                        default: cw = CW_IDLE;
                    endcase
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign controlbus = cw;
    assign tstate     = tstate_w;
    assign hlt        = hlt_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Bench for sap1_controller_sequencer: two instances (undefined opcodes as
// NOP and as HLT) share the stimulus and are checked every cycle against a
// step-number model of the SAP-1 instruction timing.
module tb_sap1_controller_sequencer;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       opcode;
    logic [1:0][11:0] cb;
    logic [1:0][5:0]  ts;
    logic [1:0]       hl;

    int errs   = 0;
    int checks = 0;

    // Model: current step number 1..6 and halted flag per instance
    int   m_k[2];
    bit   m_h[2];
    bit   m_valid = 1'b0;
    logic [11:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sap1_controller_sequencer #(.HALT_ON_UNDEF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode),
        .controlbus(cb[0]), .tstate(ts[0]), .hlt(hl[0])
    );

    sap1_controller_sequencer #(.HALT_ON_UNDEF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode),
        .controlbus(cb[1]), .tstate(ts[1]), .hlt(hl[1])
    );

    // ---------------- reference model ----------------
    function automatic bit is_undef(input logic [3:0] op);
        return !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hE || op == 4'hF);
    endfunction

    function automatic bit halts(input logic [3:0] op, input bit hou);
        return (op == 4'hF) || (hou && is_undef(op));
    endfunction

    function automatic logic [11:0] model_cw(input int k, input bit h,
                                             input logic [3:0] op);
        logic [11:0] lda[3];
        logic [11:0] add[3];
        logic [11:0] sub[3];
        logic [11:0] outw[3];
        lda  = '{12'h1A3, 12'h2C3, 12'h3E3};
        add  = '{12'h1A3, 12'h2E1, 12'h3C7};
        sub  = '{12'h1A3, 12'h2E1, 12'h3CF};
        outw = '{12'h3F2, 12'h3E3, 12'h3E3};
        if (h) return 12'h3E3;
        if (k == 1) return 12'h5E3;
        if (k == 2) return 12'hBE3;
        if (k == 3) return 12'h263;
        case (op)
            4'h0:    return lda[k-4];
            4'h1:    return add[k-4];
            4'h2:    return sub[k-4];
            4'hE:    return outw[k-4];
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic bit returns_early(input int k, input logic [3:0] op, input bit hou);
`ifdef SAP1_EARLY_RETURN_EN
        return (k == 4 && (op == 4'hE || (!hou && is_undef(op)))) || (k == 5 && op == 4'h0);
`else
        return 1'b0 && (k == 0) && (op == 4'h0) && hou;
`endif
    endfunction

    task automatic model_step(input bit r, input logic [3:0] op);
        for (int i = 0; i < 2; i++) begin
            bit hou;
            hou = (i == 1);
            if (r) begin
                m_k[i] = 1;
                m_h[i] = 1'b0;
            end else if (m_h[i]) begin
                m_k[i] = m_k[i];
            end else if (m_k[i] == 4 && halts(op, hou)) begin
                m_h[i] = 1'b1;
                m_k[i] = 5;
            end else if (returns_early(m_k[i], op, hou)) begin
                m_k[i] = 1;
            end else begin
                m_k[i] = (m_k[i] % 6) + 1;
            end
        end
        if (r) m_valid = 1'b1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs, compare settled outputs, then take one clock edge
    task automatic cyc(input bit r, input logic [3:0] op);
        rst    = r;
        opcode = op;
        #1;
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                exp_q.push_back(model_cw(m_k[i], m_h[i], op));
                check($sformatf("cw%0d", i), cb[i], exp_q.pop_front());
                check($sformatf("tstate%0d", i), {6'd0, ts[i]}, {6'd0, 6'(1 << (m_k[i] - 1))});
                check($sformatf("hlt%0d", i), {11'd0, hl[i]}, {11'd0, m_h[i]});
            end
        end
        @(posedge clk);
        model_step(r, op);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [3:0] op);
        for (int j = 0; j < n; j++) cyc(1'b0, op);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        opcode = 4'h0;
        @(negedge clk);
        cyc(1'b1, 4'h0);

        // LDA through a full cycle, back to T1
        run(7, 4'h0);
        // SUB then ADD
        cyc(1'b1, 4'h2); run(7, 4'h2);
        cyc(1'b1, 4'h1); run(7, 4'h1);
        // HLT at T4, hold for 20 clocks, then reset
        cyc(1'b1, 4'hF); run(24, 4'hF);
        cyc(1'b1, 4'h0); run(2, 4'h0);
        // Reset in T5 of ADD
        cyc(1'b1, 4'h1); run(4, 4'h1); cyc(1'b1, 4'h1); run(3, 4'h1);
        // Undefined opcode
        cyc(1'b1, 4'h7); run(9, 4'h7);
        // OUT followed by LDA
        cyc(1'b1, 4'hE); run(4, 4'hE); run(7, 4'h0);
        // Opcode changing freely during fetch
        cyc(1'b1, 4'h3);
        for (int j = 0; j < 3; j++) cyc(1'b0, 4'($urandom_range(0, 15)));

        // Randomized traffic
        for (int j = 0; j < 500; j++) begin
            logic [3:0] op;
            int sel;
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1:    op = 4'h0;
                2, 3:    op = 4'h1;
                4, 5:    op = 4'h2;
                6, 7:    op = 4'hE;
                8:       op = 4'hF;
                default: op = 4'($urandom_range(3, 13));
            endcase
            cyc($urandom_range(0, 15) == 0, op);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
